result_buffer: RTL and testbench
================================

# result_buffer

Decoupling buffer placed directly downstream of the fetch/decode/execute pipeline. Each cycle it captures the execute stage's registered result word, opcode and zero flag, stores up to DEPTH entries in order, and presents them to a consumer (write-back, trace or display logic) through a valid/ready handshake. It also keeps a sticky overflow flag and a saturating count of zero results for debug.

## Interface

Parameters:
- DEPTH, 8: number of entries; power of two, ≥ 2.
- CW, $clog2(DEPTH)+1: width of the occupancy count (derived, not overridden).

Ports:
- clk_RB  in  1  clock; all state updates on the rising edge.
- rstn_RB  in  1  reset, asynchronous, active-low.
- clear_RB  in  1  synchronous flush.
- valid_in_RB  in  1  producer has an entry this cycle.
- res_in_RB  in  32  execute result.
- op_in_RB  in  6  opcode of the instruction.
- zf_in_RB  in  1  ALU zero flag.
- ready_in_RB  out  1  buffer can accept: high when not full.
- valid_out_RB  out  1  head entry available: high when not empty.
- ready_out_RB  in  1  consumer takes the head entry.
- res_out_RB  out  32  head result; 0 when empty.
- op_out_RB  out  6  head opcode; 0 when empty.
- zf_out_RB  out  1  head zero flag; 0 when empty.
- count_RB  out  CW  current occupancy, 0..DEPTH.
- ovf_RB  out  1  sticky: an entry was offered while full.
- zcnt_RB  out  16  accepted entries with zf_in_RB=1; saturates at 16'hFFFF.

## Operation

- Storage: DEPTH×39-bit array ({op, zf, res}). Write pointer and read pointer are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is CW bits.
- push = valid_in_RB & ready_in_RB. Writes the entry at the write pointer, advances the write pointer, and increments zcnt_RB if zf_in_RB=1 and zcnt_RB≠16'hFFFF.
- pop = valid_out_RB & ready_out_RB. Advances the read pointer.
- count_RB: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full is count_RB==DEPTH; empty is count_RB==0. ready_in_RB and valid_out_RB decode the registered count only. There is no combinational path from ready_out_RB to ready_in_RB.
- When full, push and pop in the same cycle do not both occur: ready_in_RB=0, so only the pop occurs and count goes to DEPTH−1.
- When empty, a push occurs and no pop (valid_out_RB=0). There is no fall-through.
- valid_in_RB=1 while full: the entry is dropped, ovf_RB is set, and the pointers are unchanged.
- ovf_RB stays set until clear_RB or reset.
- Head outputs read the array at the read pointer combinationally and are forced to 0 while empty.
- clear_RB=1: on the next edge, pointers, count_RB, ovf_RB and zcnt_RB go to 0. clear_RB has priority over a simultaneous push or pop; that push is not stored and that pop is not counted. Array contents are not cleared.
- Reset: asserting rstn_RB low immediately forces all pointers, count_RB, ovf_RB and zcnt_RB to 0. Reset in mid-operation discards all entries. After reset, ready_in_RB=1, valid_out_RB=0 and all head outputs are 0. The array is not reset.

## Timing

- Push at edge N: the entry is visible on the head outputs with valid_out_RB=1 from edge N onward, i.e. in cycle N+1. Latency is 1 cycle.
- Pop at edge N: the next entry, or zeros if now empty, is on the head outputs after edge N.
- Steady state, with the producer valid every cycle and the consumer ready every cycle: one entry per cycle, and count_RB holds at 1 after the first push.
- ready_in_RB, valid_out_RB, count_RB, ovf_RB and zcnt_RB are registered-state decodes, so they are glitch-free relative to the inputs.
- Producer inputs are sampled only on the edge. The execute stage's registered outputs drive them directly.

## Test plan

1. Reset then idle: hold rstn_RB low, release it, keep valid_in_RB=0 → count_RB=0, ready_in_RB=1, valid_out_RB=0, res_out_RB=0, ovf_RB=0, zcnt_RB=0.
2. Fill and drain: with ready_out_RB=0, push 8 entries res=1..8, op=0, zf=0 → count_RB=8, ready_in_RB=0. Then set ready_out_RB=1 → res_out_RB reads 1..8 on consecutive cycles, followed by valid_out_RB=0.
3. Overflow: while full, drive valid_in_RB=1 with res=32'hDEAD → ovf_RB=1, count_RB stays 8, and 32'hDEAD never appears at the output. Then pulse clear_RB → ovf_RB=0 and count_RB=0.
4. Wrap-around under streaming: run 20 consecutive cycles of push and pop with res=n → the output sequence equals the input sequence delayed by 1 cycle, count_RB=1 throughout, and the pointers wrap with no loss.
5. Zero counting: push 5 entries with zf pattern 1,0,1,1,0, plus one dropped entry with zf=1 while full → zcnt_RB=3; the head zf_out_RB order matches the pushed pattern.
6. Reset mid-operation: with 3 entries stored, pulse rstn_RB low between clock edges → count_RB=0 and valid_out_RB=0 immediately. A subsequent push of 32'h5 is the first value seen at res_out_RB.

Source files
------------

// File: rtl/result_buffer.sv
// In-order result buffer between the execute stage and its consumer; an entry pushed at edge N is at the head from cycle N+1 on.
// ready_in_RB drops only when full and valid_out_RB rises only when non-empty, both decoded from registered count; offers while full are dropped and flagged.
module result_buffer #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_RB,
  input  logic          rstn_RB,
  input  logic          clear_RB,
  input  logic          valid_in_RB,
  input  logic [31:0]   res_in_RB,
  input  logic [5:0]    op_in_RB,
  input  logic          zf_in_RB,
  output logic          ready_in_RB,
  output logic          valid_out_RB,
  input  logic          ready_out_RB,
  output logic [31:0]   res_out_RB,
  output logic [5:0]    op_out_RB,
  output logic          zf_out_RB,
  output logic [CW-1:0] count_RB,
  output logic          ovf_RB,
  output logic [15:0]   zcnt_RB
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [5:0]  op;
    logic        zf;
    logic [31:0] res;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   zcnt_q, zcnt_d;

  logic   full, empty, push, pop;
  entry_t in_entry, head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign ready_in_RB  = ~full;
  assign valid_out_RB = ~empty;

  assign push = valid_in_RB & ~full;
  assign pop  = ready_out_RB & ~empty;

  assign in_entry = '{op: op_in_RB, zf: zf_in_RB, res: res_in_RB};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    zcnt_d   = zcnt_q;
    if (clear_RB) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      zcnt_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (zf_in_RB && (zcnt_q != 16'hFFFF)) begin
          zcnt_d = zcnt_q + 16'd1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (valid_in_RB && full) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_RB or negedge rstn_RB) begin
    if (!rstn_RB) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      zcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      zcnt_q   <= zcnt_d;
    end
  end

  // Storage is deliberately unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk_RB) begin
    if (push && !clear_RB) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign res_out_RB = empty ? 32'd0 : head.res;
  assign op_out_RB  = empty ? 6'd0  : head.op;
  assign zf_out_RB  = empty ? 1'b0  : head.zf;

  assign count_RB = count_q;
  assign ovf_RB   = ovf_q;
  assign zcnt_RB  = zcnt_q;

endmodule

// File: tb/tb_result_buffer.sv
// Scoreboard bench for result_buffer: directed pushes enqueue expected heads, a negedge monitor checks every popped entry.
module tb_result_buffer;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_RB = 1'b0;
  logic          rstn_RB;
  logic          clear_RB;
  logic          valid_in_RB;
  logic [31:0]   res_in_RB;
  logic [5:0]    op_in_RB;
  logic          zf_in_RB;
  logic          ready_in_RB;
  logic          valid_out_RB;
  logic          ready_out_RB;
  logic [31:0]   res_out_RB;
  logic [5:0]    op_out_RB;
  logic          zf_out_RB;
  logic [CW-1:0] count_RB;
  logic          ovf_RB;
  logic [15:0]   zcnt_RB;

  result_buffer #(.DEPTH(DEPTH)) dut (
    .clk_RB       (clk_RB),
    .rstn_RB      (rstn_RB),
    .clear_RB     (clear_RB),
    .valid_in_RB  (valid_in_RB),
    .res_in_RB    (res_in_RB),
    .op_in_RB     (op_in_RB),
    .zf_in_RB     (zf_in_RB),
    .ready_in_RB  (ready_in_RB),
    .valid_out_RB (valid_out_RB),
    .ready_out_RB (ready_out_RB),
    .res_out_RB   (res_out_RB),
    .op_out_RB    (op_out_RB),
    .zf_out_RB    (zf_out_RB),
    .count_RB     (count_RB),
    .ovf_RB       (ovf_RB),
    .zcnt_RB      (zcnt_RB)
  );

  always #5 clk_RB = ~clk_RB;

  int vectors     = 0;
  int miscompares = 0;
  logic [38:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted head must match the oldest expected entry.
  always @(negedge clk_RB) begin
    if (rstn_RB === 1'b1) begin
      if (valid_out_RB && ready_out_RB) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop_res", res_out_RB, 32'hFFFF_FFFF);
        end else begin
          logic [38:0] e;
          e = sb.pop_front();
          chk("head_res", res_out_RB, e[31:0]);
          chk("head_op",  {26'd0, op_out_RB}, {26'd0, e[38:33]});
          chk("head_zf",  {31'd0, zf_out_RB}, {31'd0, e[32]});
        end
      end else if (!valid_out_RB) begin
        chk("empty_head_zero", {res_out_RB[31:7], op_out_RB, zf_out_RB} | res_out_RB, 32'd0);
      end
    end
  end

  task automatic drive(input logic [31:0] r, input logic [5:0] o, input logic z,
                       input logic exp_rdy, input bit enq);
    valid_in_RB = 1'b1;
    res_in_RB   = r;
    op_in_RB    = o;
    zf_in_RB    = z;
    chk("ready_in_at_offer", {31'd0, ready_in_RB}, {31'd0, exp_rdy});
    if (enq) sb.push_back({o, z, r});
    @(posedge clk_RB); #1;
    valid_in_RB = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    ready_out_RB = 1'b1;
    while (valid_out_RB && n < 40) begin
      @(posedge clk_RB); #1;
      n++;
    end
    chk({name, "_drained"}, {31'd0, valid_out_RB}, 32'd0);
    chk({name, "_sb_empty"}, sb.size(), 32'd0);
    ready_out_RB = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn_RB = 1'b0; clear_RB = 1'b0; valid_in_RB = 1'b0;
    res_in_RB = '0; op_in_RB = '0; zf_in_RB = 1'b0; ready_out_RB = 1'b0;

    // 1. reset then idle
    repeat (3) @(posedge clk_RB);
    #3 rstn_RB = 1'b1;
    @(posedge clk_RB); #1;
    chk("rst_count",  {28'd0, count_RB}, 32'd0);
    chk("rst_ready",  {31'd0, ready_in_RB}, 32'd1);
    chk("rst_valid",  {31'd0, valid_out_RB}, 32'd0);
    chk("rst_res",    res_out_RB, 32'd0);
    chk("rst_ovf",    {31'd0, ovf_RB}, 32'd0);
    chk("rst_zcnt",   {16'd0, zcnt_RB}, 32'd0);

    // 2. fill to full, 3. overflow offer, then drain
    for (int i = 1; i <= 8; i++) drive(32'(i), 6'd0, 1'b0, 1'b1, 1'b1);
    chk("full_count", {28'd0, count_RB}, 32'd8);
    chk("full_ready", {31'd0, ready_in_RB}, 32'd0);
    chk("full_head",  res_out_RB, 32'd1);
    drive(32'hDEAD, 6'd0, 1'b0, 1'b0, 1'b0);
    chk("ovf_set",     {31'd0, ovf_RB}, 32'd1);
    chk("ovf_count",   {28'd0, count_RB}, 32'd8);
    drain("fill");
    chk("ovf_sticky",  {31'd0, ovf_RB}, 32'd1);

    // clear wins over a simultaneous push
    drive(32'h11, 6'd1, 1'b1, 1'b1, 1'b0);
    drive(32'h22, 6'd2, 1'b1, 1'b1, 1'b0);
    chk("pre_clear_count", {28'd0, count_RB}, 32'd2);
    clear_RB = 1'b1;
    valid_in_RB = 1'b1; res_in_RB = 32'h77; zf_in_RB = 1'b1;
    @(posedge clk_RB); #1;
    clear_RB = 1'b0; valid_in_RB = 1'b0;
    chk("clear_count", {28'd0, count_RB}, 32'd0);
    chk("clear_ovf",   {31'd0, ovf_RB}, 32'd0);
    chk("clear_zcnt",  {16'd0, zcnt_RB}, 32'd0);
    chk("clear_valid", {31'd0, valid_out_RB}, 32'd0);

    // 4. streaming with wrap-around
    ready_out_RB = 1'b1;
    for (int n = 0; n < 20; n++) begin
      drive(32'(100 + n), 6'(n), 1'b0, 1'b1, 1'b1);
      chk("stream_count", {28'd0, count_RB}, 32'd1);
    end
    drain("stream");

    // 5. zero counting, including a dropped zf=1 offer while full
    drive(32'h201, 6'h21, 1'b1, 1'b1, 1'b1);
    drive(32'h202, 6'h22, 1'b0, 1'b1, 1'b1);
    drive(32'h203, 6'h23, 1'b1, 1'b1, 1'b1);
    drive(32'h204, 6'h24, 1'b1, 1'b1, 1'b1);
    drive(32'h205, 6'h25, 1'b0, 1'b1, 1'b1);
    for (int i = 6; i <= 8; i++) drive(32'(32'h200 + i), 6'h20, 1'b0, 1'b1, 1'b1);
    drive(32'h2FF, 6'h3F, 1'b1, 1'b0, 1'b0);
    chk("zcnt_value", {16'd0, zcnt_RB}, 32'd3);
    chk("zcnt_ovf",   {31'd0, ovf_RB}, 32'd1);
    drain("zf");

    // 6. asynchronous reset mid-operation
    drive(32'h31, 6'd1, 1'b0, 1'b1, 1'b0);
    drive(32'h32, 6'd2, 1'b1, 1'b1, 1'b0);
    drive(32'h33, 6'd3, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_count", {28'd0, count_RB}, 32'd3);
    #2 rstn_RB = 1'b0;
    #1;
    chk("midrst_count", {28'd0, count_RB}, 32'd0);
    chk("midrst_valid", {31'd0, valid_out_RB}, 32'd0);
    chk("midrst_zcnt",  {16'd0, zcnt_RB}, 32'd0);
    chk("midrst_ovf",   {31'd0, ovf_RB}, 32'd0);
    #1 rstn_RB = 1'b1;
    @(posedge clk_RB); #1;
    drive(32'h5, 6'h05, 1'b0, 1'b1, 1'b1);
    chk("post_rst_head", res_out_RB, 32'h5);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
